// File: rtl/apb_master.sv
// apb_master: single-outstanding valid/ready to APB requester with a pready timeout
module apb_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam logic [8:0] TO = 9'(TIMEOUT_CYC);
  state_t state, state_nx;
  logic [7:0] wait_cnt;
  logic timeout;
  // this pready-low cycle is the TIMEOUT_CYC-th one of the access phase
  assign timeout = ({1'b0, wait_cnt} + 9'd1) >= TO;
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    cmd_ready = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        state_nx = cmd_valid ? SETUP : IDLE;
      end
      SETUP: begin
        psel = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel = 1'b1;
        penable = 1'b1;
        state_nx = (pready || timeout) ? RESP : ACCESS;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx = rsp_ready ? IDLE : RESP;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        paddr <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        wait_cnt <= '0;
      end
      if (state == ACCESS) begin
        // a ready slave wins over a timeout falling on the same edge
        if (pready) begin
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_err <= 1'b0;
        end else begin
          wait_cnt <= (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
          if (timeout) begin
            rsp_rdata <= '0;
            rsp_err <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized transactions against a transaction-level timing model of apb_master
module tb_apb_master;
  localparam int T = 4;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 0, pready = 0;
  logic [7:0] cmd_addr = 0, cmd_wdata = 0, prdata = 0;
  logic cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [7:0] rsp_rdata, paddr, pwdata;
  int vectors = 0, errors = 0;
  int cycn = 0, t_acc = 0, t_rsp = 0, pe_cnt = 0;
  logic chk = 0, rv_q = 0;
  logic e_cr, e_ps, e_pe, e_rv, e_er, e_chk_rsp;
  logic [7:0] e_rd, last_rd;
  logic last_er;
  logic m_wr = 0;
  logic [7:0] m_addr = 0, m_wd = 0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cycn, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cycn++;
    if (chk) begin
      cmp("cmd_ready", 8'(cmd_ready), 8'(e_cr));
      cmp("psel", 8'(psel), 8'(e_ps));
      cmp("penable", 8'(penable), 8'(e_pe));
      cmp("rsp_valid", 8'(rsp_valid), 8'(e_rv));
      cmp("paddr", paddr, m_addr);
      cmp("pwdata", pwdata, m_wd);
      cmp("pwrite", 8'(pwrite), 8'(m_wr));
      if (e_chk_rsp) begin
        cmp("rsp_rdata", rsp_rdata, e_rd);
        cmp("rsp_err", 8'(rsp_err), 8'(e_er));
      end
    end
    if (cmd_valid && cmd_ready) t_acc = cycn;
    if (rsp_valid && !rv_q) t_rsp = cycn;
    rv_q = rsp_valid;
    if (rsp_valid) begin
      last_rd = rsp_rdata;
      last_er = rsp_err;
    end
    if (psel && !penable) pe_cnt = 0;
    else if (penable) pe_cnt++;
  end

  task automatic cyc(input logic cr, ps, pe, rv, cr_rsp);
    e_cr = cr; e_ps = ps; e_pe = pe; e_rv = rv; e_chk_rsp = cr_rsp; chk = 1;
    @(posedge clk); #1;
  endtask

  task automatic noise();
    pready = 1'($urandom);
    prdata = 8'($urandom);
    rsp_ready = 1'($urandom);
  endtask

  // w = ACCESS cycles with pready low before it rises, bp = extra RESP cycles with rsp_ready low
  task automatic txn(input logic wr, input logic [7:0] a, d, rd, input int w, bp, gap, input logic hold_cv);
    int acc;
    logic er;
    acc = (w < T) ? w + 1 : T;
    er = (w >= T);
    for (int g = 0; g < gap; g++) begin
      cmd_valid = 0;
      noise();
      cyc(1, 0, 0, 0, 0);
    end
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    noise();
    cyc(1, 0, 0, 0, 0);
    m_wr = wr; m_addr = a; m_wd = d;
    e_rd = (er || wr) ? 8'h00 : rd;
    e_er = er;
    for (int j = 0; j <= acc + 1 + bp; j++) begin
      cmd_valid = hold_cv ? 1'b1 : 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr = 8'($urandom);
      cmd_wdata = 8'($urandom);
      noise();
      if (j >= 1 && j <= acc) begin
        pready = (j > w);
        prdata = (j > w) ? rd : 8'($urandom);
      end
      if (j > acc) rsp_ready = (j == acc + 1 + bp);
      if (j == 0) cyc(0, 1, 0, 0, 0);
      else if (j <= acc) cyc(0, 1, 1, 0, 0);
      else cyc(0, 0, 0, 1, 1);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    e_rd = 0; e_er = 0;
    cyc(1, 0, 0, 0, 1);
    rst = 1;
    txn(1, 8'h10, 8'hA5, 8'h00, 0, 0, 1, 0);
    cmp("wr0_latency", 8'(t_rsp - t_acc), 8'd3);
    cmp("wr0_penable_len", 8'(pe_cnt), 8'd1);
    cmp("wr0_rdata", last_rd, 8'h00);
    txn(0, 8'h22, 8'h00, 8'h5C, 2, 0, 1, 0);
    cmp("rd2_penable_len", 8'(pe_cnt), 8'd3);
    cmp("rd2_rdata", last_rd, 8'h5C);
    cmp("rd2_err", 8'(last_er), 8'd0);
    txn(0, 8'h40, 8'h00, 8'h77, 10, 0, 1, 0);
    cmp("to_penable_len", 8'(pe_cnt), 8'd4);
    cmp("to_err", 8'(last_er), 8'd1);
    cmp("to_rdata", last_rd, 8'h00);
    txn(1, 8'h01, 8'h3C, 8'h00, 0, 0, 0, 0);
    cmp("post_to_err", 8'(last_er), 8'd0);
    txn(0, 8'h55, 8'h00, 8'h99, 1, 5, 1, 1);
    txn(1, 8'h66, 8'h12, 8'h00, 0, 0, 0, 0);
    txn(0, 8'h70, 8'h00, 8'hC3, T - 1, 0, 1, 0);
    cmp("edge_err", 8'(last_er), 8'd0);
    cmp("edge_rdata", last_rd, 8'hC3);
    cmp("edge_penable_len", 8'(pe_cnt), 8'd4);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h2A; cmd_wdata = 8'h11;
    noise();
    cyc(1, 0, 0, 0, 0);
    m_wr = 0; m_addr = 8'h2A; m_wd = 8'h11;
    cmd_valid = 0;
    noise();
    cyc(0, 1, 0, 0, 0);
    pready = 0;
    cyc(0, 1, 1, 0, 0);
    pready = 0; rst = 0;
    cyc(0, 1, 1, 0, 0);
    rst = 1;
    m_wr = 0; m_addr = 0; m_wd = 0; e_rd = 0; e_er = 0;
    noise();
    cyc(1, 0, 0, 0, 1);
    txn(0, 8'h30, 8'h00, 8'hE1, 1, 0, 0, 0);
    cmp("post_rst_rdata", last_rd, 8'hE1);
    for (int i = 0; i < 150; i++)
      txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, T + 2)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
